// File: rtl/credit_bcd_formatter.sv
// credit_bcd_formatter
//   Converts a binary credit/price value into four BCD digits for the
//   seven-segment display block. One input bit is consumed per clock by a
//   shift-add-3 (double-dabble) engine. Digits and ovf are registered and only
//   change when a conversion completes or on reset.
//
// Ports
//   clk            system clock
//   clr            asynchronous, active-high reset
//   load           start a conversion of value (accepted only when idle)
//   value[IN_W]    unsigned binary value to display
//   busy           high from the cycle after an accepted load through the done cycle
//   done           one-cycle pulse when dig1..dig4 carry new digits
//   ovf            last converted value exceeded 9999 (display saturated)
//   dig1..dig4     thousands .. ones digit; dig4 is never blanked
//
// State   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for load; also hosts the done-pulse cycle (busy still 1)
// S_SHIFT | IN_W adjust-and-shift steps, cnt counts down to terminal count 1
// S_DONE  | bcd complete; digits, ovf and done are registered at its closing edge

module credit_bcd_formatter #(
  parameter int unsigned IN_W          = 14,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter logic [3:0]  BLANK_CODE    = 4'hF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      dig1,
  output logic [3:0]      dig2,
  output logic [3:0]      dig3,
  output logic [3:0]      dig4
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  // Leading-digit reset value: a blank display showing just "0".
  localparam logic [3:0] LEAD_RST = BLANK_LEADING ? BLANK_CODE : 4'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   src;
  logic [15:0]       bcd;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_n;

  logic              over_max;
  logic [15:0]       bcd_adj;
  logic [15:0]       bcd_shift;
  logic              z1, z2, z3;

  // Narrow inputs can never exceed 9999, so the guard folds to constant false.
  assign over_max = (IN_W >= 14) && (value > IN_W'(9999));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_shift = {bcd_adj[14:0], src[IN_W-1]};

  // Leading-zero blanking chain: a digit is blanked only if every digit to its
  // left was blanked too, so inner zeros (e.g. 1005) survive.
  always_comb begin
    z1 = BLANK_LEADING && (bcd[15:12] == 4'd0);
    z2 = z1 && (bcd[11:8] == 4'd0);
    z3 = z2 && (bcd[7:4]  == 4'd0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      ovf_n <= 1'b0;
      src   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      dig1  <= LEAD_RST;
      dig2  <= LEAD_RST;
      dig3  <= LEAD_RST;
      dig4  <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // busy is still high during the done pulse, which blocks a load there.
          if (load && !busy) begin
            busy  <= 1'b1;
            src   <= over_max ? IN_W'(9999) : value;
            ovf_n <= over_max;
            bcd   <= '0;
            cnt   <= CNT_W'(IN_W);
            state <= S_SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end

        S_SHIFT: begin
          bcd <= bcd_shift;
          src <= src << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          dig1  <= z1 ? BLANK_CODE : bcd[15:12];
          dig2  <= z2 ? BLANK_CODE : bcd[11:8];
          dig3  <= z3 ? BLANK_CODE : bcd[7:4];
          dig4  <= bcd[3:0];
          ovf   <= ovf_n;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_credit_bcd_formatter.sv
module tb_credit_bcd_formatter;

  logic        clk;
  logic        clr;
  logic        load;
  logic [13:0] value;

  logic       busy_a, done_a, ovf_a;
  logic [3:0] a1, a2, a3, a4;
  logic       busy_b, done_b, ovf_b;
  logic [3:0] b1, b2, b3, b4;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected contents of the display between conversions.
  logic [15:0] cur_a, cur_b;
  logic        cur_ovf;

  credit_bcd_formatter #(.IN_W(14), .BLANK_LEADING(1'b1), .BLANK_CODE(4'hF)) dut (
    .clk(clk), .clr(clr), .load(load), .value(value),
    .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .dig1(a1), .dig2(a2), .dig3(a3), .dig4(a4)
  );

  credit_bcd_formatter #(.IN_W(14), .BLANK_LEADING(1'b0), .BLANK_CODE(4'hF)) dut0 (
    .clk(clk), .clr(clr), .load(load), .value(value),
    .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .dig1(b1), .dig2(b2), .dig3(b3), .dig4(b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of the saturated value, leading zeros replaced by F when bl=1.
  function automatic logic [15:0] model(input int v, input bit bl);
    int s;
    int d[4];
    logic [15:0] r;
    bit lead;
    s = (v > 9999) ? 9999 : v;
    d[0] = s / 1000;
    d[1] = (s / 100) % 10;
    d[2] = (s / 10) % 10;
    d[3] = s % 10;
    lead = bl;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (lead && i < 3 && d[i] == 0) begin
        r[15-4*i -: 4] = 4'hF;
      end else begin
        r[15-4*i -: 4] = 4'(d[i]);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    clr = 1'b1; load = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    cur_a = model(0, 1'b1);
    cur_b = model(0, 1'b0);
    cur_ovf = 1'b0;
    n_checks++; if ({a1,a2,a3,a4} !== 16'hFFF0) begin n_fail++; $display("FAIL reset_dig_blank: got %h expected fff0", {a1,a2,a3,a4}); end
    n_checks++; if ({b1,b2,b3,b4} !== 16'h0000) begin n_fail++; $display("FAIL reset_dig_noblank: got %h expected 0000", {b1,b2,b3,b4}); end
    n_checks++; if ({busy_a,done_a,ovf_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/ovf=%b expected 000", {busy_a,done_a,ovf_a}); end
    clr = 1'b0;
    @(negedge clk);
  endtask

  // One load/wait/verify cycle; value is scrambled after the load edge.
  task automatic do_conversion(input int v);
    int k;
    logic [15:0] ea, eb;
    logic eo;
    ea = model(v, 1'b1);
    eb = model(v, 1'b0);
    eo = (v > 9999);
    load = 1'b1; value = 14'(v);
    @(negedge clk);
    load = 1'b0; value = 14'($urandom);
    k = 0;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_after_load(%0d): got %b expected 1", v, busy_a); end
    while (done_a !== 1'b1 && k < 40) begin
      n_checks++;
      if ({a1,a2,a3,a4} !== cur_a || {b1,b2,b3,b4} !== cur_b || ovf_a !== cur_ovf) begin
        n_fail++;
        $display("FAIL hold(%0d) k=%0d: got %h/%h ovf=%b expected %h/%h ovf=%b", v, k, {a1,a2,a3,a4}, {b1,b2,b3,b4}, ovf_a, cur_a, cur_b, cur_ovf);
      end
      @(negedge clk);
      k++;
    end
    n_checks++; if (k !== 15) begin n_fail++; $display("FAIL latency(%0d): got %0d expected 15", v, k); end
    n_checks++; if ({a1,a2,a3,a4} !== ea) begin n_fail++; $display("FAIL digits_blank(%0d): got %h expected %h", v, {a1,a2,a3,a4}, ea); end
    n_checks++; if ({b1,b2,b3,b4} !== eb) begin n_fail++; $display("FAIL digits_noblank(%0d): got %h expected %h", v, {b1,b2,b3,b4}, eb); end
    n_checks++; if (ovf_a !== eo || ovf_b !== eo) begin n_fail++; $display("FAIL ovf(%0d): got %b/%b expected %b", v, ovf_a, ovf_b, eo); end
    n_checks++; if (done_b !== 1'b1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL done_cycle(%0d): got done_b=%b busy=%b expected 1 1", v, done_b, busy_a); end
    @(negedge clk);
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL pulse_end(%0d): got done=%b busy=%b expected 0 0", v, done_a, busy_a); end
    cur_a = ea; cur_b = eb; cur_ovf = eo;
  endtask

  task automatic test_basic();
    do_conversion(1234);
  endtask

  task automatic test_directed();
    int vals[8] = '{0, 50, 1005, 10000, 7, 9999, 16383, 9};
    foreach (vals[i]) do_conversion(vals[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      do_conversion(int'($urandom_range(0, 16383)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int pulses;
    load = 1'b1; value = 14'd1234;
    @(negedge clk);
    load = 1'b0;
    k = 0; pulses = 0;
    while (k < 45) begin
      if (k == 5) begin load = 1'b1; value = 14'd5678; end
      else load = 1'b0;
      if (done_a === 1'b1) begin
        pulses++;
        load = 1'b1; value = 14'd5678;
      end
      @(negedge clk);
      k++;
    end
    load = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    n_checks++; if ({a1,a2,a3,a4} !== 16'h1234) begin n_fail++; $display("FAIL b2b_digits: got %h expected 1234", {a1,a2,a3,a4}); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", busy_a); end
    cur_a = model(1234, 1'b1); cur_b = model(1234, 1'b0); cur_ovf = 1'b0;
  endtask

  task automatic test_clr_abort();
    int pulses;
    load = 1'b1; value = 14'd4321;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    clr = 1'b1;
    #1;
    n_checks++; if ({a1,a2,a3,a4} !== 16'hFFF0 || {b1,b2,b3,b4} !== 16'h0000) begin n_fail++; $display("FAIL abort_digits: got %h/%h expected fff0/0000", {a1,a2,a3,a4}, {b1,b2,b3,b4}); end
    n_checks++; if ({busy_a,done_a,ovf_a} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b expected 000", {busy_a,done_a,ovf_a}); end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    cur_a = model(0, 1'b1); cur_b = model(0, 1'b0); cur_ovf = 1'b0;
    do_conversion(42);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_back_to_back();
    test_clr_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
